ifmap_wadr_gen: RTL
===================

// Module: ifmap_wadr_gen
// PURPOSE
//  Write-side controller for the ifmap double buffer. Accepts a valid/ready stream of
//  DATA_WIDTH ifmap words and packs NUM_LANES of them into one bank word (lane 0 = LSBs).
//  Generates sequential write addresses for one tile of IX0*IY0*IC1 bank words.
//  Requests a bank swap only once the read side has released its bank.
// PARAMETERS
//  BANK_ADDR_WIDTH  8   bank address width; also width of each config field
//  DATA_WIDTH       16  width of one streamed input word
//  NUM_LANES        4   input words packed per bank word (>=1)
// PORTS
//  clk          in   1                          clock
//  rst_n        in   1                          synchronous, active-low reset
//  config_en    in   1                          load config_data (aborts any partial tile)
//  config_data  in   BANK_ADDR_WIDTH*3          {IX0, IY0, IC1}, IX0 in MSBs
//  in_data      in   DATA_WIDTH                 streamed ifmap word
//  in_valid     in   1                          in_data valid
//  in_ready     out  1                          block accepts in_data this cycle
//  wen          out  1                          bank write strobe (registered)
//  wadr         out  BANK_ADDR_WIDTH            bank write address (registered)
//  wdata        out  DATA_WIDTH*NUM_LANES       packed bank word (registered)
//  wbank        out  1                          bank currently being written
//  rd_done      in   1                          1-cycle pulse: reader finished its bank
//  switch       out  1                          1-cycle pulse: swap double-buffer banks
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): config regs=0, state=FILL, lane cnt=0, adr cnt=0,
//    wen=0, wadr=0, wdata=0, switch=0, wbank=0, rd_free=1 (reader holds no data).
//  - Beat accepted when in_valid && in_ready. in_ready = (state==FILL) && cfg_ok.
//    cfg_ok = IX0!=0 && IY0!=0 && IC1!=0; after reset in_ready=0 until a valid config.
//  - Tile length: last_adr = IX0*IY0*IC1-1, computed full width and truncated to
//    BANK_ADDR_WIDTH; config must keep the product <= 2**BANK_ADDR_WIDTH.
//  - Packing: beat at lane k goes to wdata[k*DATA_WIDTH +: DATA_WIDTH]. The lane counter
//    wraps after NUM_LANES-1. On the beat completing a word, the next cycle has wen=1,
//    wadr=adr cnt, wdata=packed word (1-cycle latency); adr cnt then increments.
//    Otherwise wen=0 and wadr/wdata hold. in_valid gaps never alter packing.
//  - FSM FILL -> WAIT: on the beat completing word last_adr. in_ready drops next cycle,
//    the same cycle wen=1 for that word.
//  - WAIT -> SWAP: when (rd_free || rd_done). Otherwise remain in WAIT, in_ready=0.
//  - SWAP: switch=1 for exactly this cycle. At its end: wbank toggles, adr cnt=0,
//    lane cnt=0, rd_free cleared; next state FILL.
//  - rd_free: set by rd_done in any state. If set and clear coincide (rd_done during
//    SWAP), set wins.
//  - config_en (any state): latch config; state=FILL, lane cnt=0, adr cnt=0. The
//    partial word is discarded with no wen. wbank and rd_free are unchanged. A beat in
//    the config_en cycle is not accepted (in_ready forced 0 that cycle).
//  - Reset mid-operation restores all reset values, including wbank=0 and rd_free=1.
// TESTING
//  1. Reset, no config, in_valid=1 -> in_ready=0, wen=0, switch=0, wbank=0, wadr=0.
//  2. Config IX0=2,IY0=2,IC1=1, stream values 1..16 back-to-back -> 4 wen pulses with
//     wadr 0..3; first wdata={16'd4,16'd3,16'd2,16'd1}. Beat 16 at cycle T gives
//     wen at T+1, switch at T+2, wbank=1 and in_ready=1 at T+3.
//  3. Second tile of 16 beats with no rd_done -> stays WAIT, in_ready=0 for 50 cycles.
//     rd_done at cycle C -> switch=1 at C+1, wbank=0 at C+2.
//  4. rd_done pulsed mid-FILL of tile 3 -> switch issued 2 cycles after the last beat,
//     no stall.
//  5. Random in_valid gaps (50%) over a tile -> identical wdata/wadr sequence to case 2.
//  6. config_en after 6 beats -> no wen for beats 5-6; the next wen has wadr=0 and
//     wdata built from the 4 beats following config.

Source files
------------

// File: rtl/ifmap_wadr_gen_if.sv
// ----------------------------------------------------------------------------
// ifmap_wadr_gen_if : config, input stream, bank write port and swap handshake
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface ifmap_wadr_gen_if #(
    parameter int BANK_ADDR_WIDTH = 8,
    parameter int DATA_WIDTH      = 16,
    parameter int NUM_LANES       = 4
);
    logic                              config_en;
    logic [BANK_ADDR_WIDTH*3-1:0]      config_data;
    logic [DATA_WIDTH-1:0]             in_data;
    logic                              in_valid;
    logic                              in_ready;
    logic                              wen;
    logic [BANK_ADDR_WIDTH-1:0]        wadr;
    logic [DATA_WIDTH*NUM_LANES-1:0]   wdata;
    logic                              wbank;
    logic                              rd_done;
    logic                              switch;

    modport master (
        output config_en, config_data, in_data, in_valid, rd_done,
        input  in_ready, wen, wadr, wdata, wbank, switch
    );

    modport slave (
        input  config_en, config_data, in_data, in_valid, rd_done,
        output in_ready, wen, wadr, wdata, wbank, switch
    );
endinterface

`default_nettype wire

// File: rtl/ifmap_wadr_gen.sv
// ----------------------------------------------------------------------------
// ifmap_wadr_gen : packs streamed ifmap words into bank words, writes one tile,
//                  then swaps double-buffer banks once the reader is free.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ifmap_wadr_gen #(
    parameter int BANK_ADDR_WIDTH = 8,
    parameter int DATA_WIDTH      = 16,
    parameter int NUM_LANES       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    ifmap_wadr_gen_if.slave   bus
);
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int WORD_W = DATA_WIDTH * NUM_LANES;
    localparam int PROD_W = 3 * BANK_ADDR_WIDTH;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        WAIT = 2'd1,
        SWAP = 2'd2
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [BANK_ADDR_WIDTH-1:0] ix0;
    logic [BANK_ADDR_WIDTH-1:0] iy0;
    logic [BANK_ADDR_WIDTH-1:0] ic1;
    logic [BANK_ADDR_WIDTH-1:0] adr_cnt;
    logic [BANK_ADDR_WIDTH-1:0] last_adr;
    logic [PROD_W-1:0]          tile_len;
    logic [LANE_W-1:0]          lane_cnt;
    logic [WORD_W-1:0]          pack_buf;
    logic [WORD_W-1:0]          packed_word;
    logic                       cfg_ok;
    logic                       in_ready;
    logic                       accept;
    logic                       word_done;
    logic                       tile_done;
    logic                       switch_pulse;
    logic                       rd_free;
    logic                       wr_en;
    logic [BANK_ADDR_WIDTH-1:0] wr_adr;
    logic [WORD_W-1:0]          wr_data;
    logic                       bank_sel;

    // Product kept full width so a tile of exactly 2**BANK_ADDR_WIDTH words
    // still yields an all-ones last address after truncation.
    assign tile_len  = PROD_W'(ix0) * PROD_W'(iy0) * PROD_W'(ic1);
    assign last_adr  = BANK_ADDR_WIDTH'(tile_len - PROD_W'(1));
    assign cfg_ok    = (ix0 != '0) && (iy0 != '0) && (ic1 != '0);
    assign in_ready  = (state == FILL) && cfg_ok && !bus.config_en;
    assign accept    = bus.in_valid && in_ready;
    assign word_done = accept && (lane_cnt == LAST_LANE);
    assign tile_done = word_done && (adr_cnt == last_adr);

    always_comb begin
        packed_word = pack_buf;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (lane_cnt == LANE_W'(k)) begin
                packed_word[k*DATA_WIDTH +: DATA_WIDTH] = bus.in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        switch_pulse = 1'b0;
        case (state)
            FILL: if (tile_done) state_nxt = WAIT;
            WAIT: if (rd_free || bus.rd_done) state_nxt = SWAP;
            SWAP: begin
                switch_pulse = !bus.config_en;
                state_nxt    = FILL;
            end
            default: state_nxt = FILL;
        endcase
        if (bus.config_en) begin
            state_nxt = FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ix0      <= '0;
            iy0      <= '0;
            ic1      <= '0;
            lane_cnt <= '0;
            adr_cnt  <= '0;
            pack_buf <= '0;
            wr_en    <= 1'b0;
            wr_adr   <= '0;
            wr_data  <= '0;
            bank_sel <= 1'b0;
            rd_free  <= 1'b1;
        end else begin
            wr_en <= word_done;
            if (word_done) begin
                wr_adr  <= adr_cnt;
                wr_data <= packed_word;
            end

            // A config load overrides a pending swap: the bank is not toggled.
            if (bus.config_en) begin
                {ix0, iy0, ic1} <= bus.config_data;
                lane_cnt        <= '0;
                adr_cnt         <= '0;
            end else if (state == SWAP) begin
                bank_sel <= ~bank_sel;
                lane_cnt <= '0;
                adr_cnt  <= '0;
            end else if (accept) begin
                pack_buf <= packed_word;
                if (word_done) begin
                    lane_cnt <= '0;
                    adr_cnt  <= adr_cnt + BANK_ADDR_WIDTH'(1);
                end else begin
                    lane_cnt <= lane_cnt + LANE_W'(1);
                end
            end

            if (bus.rd_done) begin
                rd_free <= 1'b1;
            end else if ((state == SWAP) && !bus.config_en) begin
                rd_free <= 1'b0;
            end
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.wen      = wr_en;
    assign bus.wadr     = wr_adr;
    assign bus.wdata    = wr_data;
    assign bus.wbank    = bank_sel;
    assign bus.switch   = switch_pulse;

endmodule

`default_nettype wire
